// File: rtl/melody_sequencer_if.sv
// Control/status and ROM bus of the melody sequencer. When MELODY_LOOP_EN is
// defined the bundle also carries the loop request.
interface melody_sequencer_if #(
   parameter int DIV_W  = 16,
   parameter int DUR_W  = 8,
   parameter int ADDR_W = 6
);
   logic                   start;
   logic                   stop;
   logic [ADDR_W-1:0]      rom_addr;
   logic [DIV_W+DUR_W-1:0] rom_data;
   logic                   busy;
   logic                   note_active;
   logic                   done;
   logic                   square_wave_final;
`ifdef MELODY_LOOP_EN
   logic                   loop;

   modport master (
      output start, stop, rom_data, loop,
      input  rom_addr, busy, note_active, done, square_wave_final
   );
   modport slave (
      input  start, stop, rom_data, loop,
      output rom_addr, busy, note_active, done, square_wave_final
   );
`else
   modport master (
      output start, stop, rom_data,
      input  rom_addr, busy, note_active, done, square_wave_final
   );
   modport slave (
      input  start, stop, rom_data,
      output rom_addr, busy, note_active, done, square_wave_final
   );
`endif
endinterface

// File: rtl/melody_sequencer.sv
// Table-driven melody player: fetches {div, dur} entries from a synchronous ROM
// and plays them on one square-wave generator. MELODY_LOOP_EN adds replay on end.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, all outputs low
// S_FETCH | rom_addr presented, ROM data arrives next cycle
// S_LOAD  | capture entry; end marker, skip (dur=0) or start playing
// S_PLAY  | tone or rest for dur tempo ticks
// S_GAP   | silent inter-note gap of GAP_TICKS ticks
// S_DONE  | one-cycle done pulse, then back to idle
module melody_sequencer #(
   parameter int DIV_W     = 16,
   parameter int DUR_W     = 8,
   parameter int ADDR_W    = 6,
   parameter int TICK_DIV  = 2800000,
   parameter int GAP_TICKS = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   melody_sequencer_if.slave  bus
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_W  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
   localparam logic [DIV_W-1:0]  DIV_END   = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DIV_W-1:0]  r_div, r_half;
   logic [DUR_W-1:0]  r_dur, r_dur_cnt;
   logic [TICK_W-1:0] r_tick;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic              r_sq, r_done;

   logic [DIV_W-1:0]  w_div;
   logic [DUR_W-1:0]  w_dur;
   logic              w_is_end, w_addr_last, w_tick_wrap, w_half_wrap;
   logic              w_play_end, w_gap_end, w_loop;
   logic              w_advance, w_finish;

   assign w_div       = bus.rom_data[DIV_W+DUR_W-1:DUR_W];
   assign w_dur       = bus.rom_data[DUR_W-1:0];
   assign w_is_end    = (w_div == DIV_END);
   assign w_addr_last = (r_addr == {ADDR_W{1'b1}});
   assign w_tick_wrap = (r_tick == TICK_LAST);
   assign w_half_wrap = (r_half == r_div - DIV_W'(1));
   assign w_play_end  = w_tick_wrap && (r_dur_cnt == r_dur - DUR_W'(1));
   assign w_gap_end   = w_tick_wrap && (r_gap_cnt == GAP_LAST);

`ifdef MELODY_LOOP_EN
   assign w_loop = bus.loop;
`else
   assign w_loop = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // w_advance: finished an entry; w_finish: end marker or address wrap
   always_comb begin
      w_state_nxt = r_state;
      w_advance   = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
         S_FETCH: w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (w_is_end)              w_finish    = 1'b1;
            else if (w_dur == '0)      w_advance   = 1'b1;
            else                       w_state_nxt = S_PLAY;
         end
         S_PLAY: begin
            if (w_play_end) begin
               if (GAP_TICKS > 0) w_state_nxt = S_GAP;
               else               w_advance   = 1'b1;
            end
         end
         S_GAP:   if (w_gap_end) w_advance = 1'b1;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_advance) begin
         if (w_addr_last) w_finish    = 1'b1;
         else             w_state_nxt = S_FETCH;
      end
      if (w_finish) w_state_nxt = w_loop ? S_FETCH : S_DONE;
      // stop beats everything, including a simultaneous start
      if (bus.stop) begin
         w_state_nxt = S_IDLE;
         w_advance   = 1'b0;
         w_finish    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_div     <= '0;
         r_dur     <= '0;
         r_half    <= '0;
         r_dur_cnt <= '0;
         r_tick    <= '0;
         r_gap_cnt <= '0;
         r_sq      <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_state_nxt == S_IDLE) begin
            r_addr    <= '0;
            r_div     <= '0;
            r_dur     <= '0;
            r_half    <= '0;
            r_dur_cnt <= '0;
            r_tick    <= '0;
            r_gap_cnt <= '0;
            r_sq      <= 1'b0;
         end else begin
            case (r_state)
               S_LOAD: begin
                  r_div     <= w_div;
                  r_dur     <= w_dur;
                  r_half    <= '0;
                  r_dur_cnt <= '0;
                  r_tick    <= '0;
                  r_gap_cnt <= '0;
                  r_sq      <= 1'b0;
               end
               S_PLAY: begin
                  r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
                  if (w_tick_wrap) r_dur_cnt <= r_dur_cnt + DUR_W'(1);
                  if (r_div != '0) begin
                     r_half <= w_half_wrap ? '0 : r_half + DIV_W'(1);
                     if (w_half_wrap) r_sq <= ~r_sq;
                  end
                  if (w_play_end) r_sq <= 1'b0;
               end
               S_GAP: begin
                  r_tick <= w_tick_wrap ? '0 : r_tick + TICK_W'(1);
                  if (w_tick_wrap) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
               default: ;
            endcase
            if (w_finish)       r_addr <= '0;
            else if (w_advance) r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   assign bus.rom_addr          = r_addr;
   assign bus.busy              = (r_state != S_IDLE);
   assign bus.note_active       = (r_state == S_PLAY) && (r_div != '0);
   assign bus.done              = r_done;
   assign bus.square_wave_final = r_sq;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4, GAP_TICKS=1, ADDR_W=2.
// Cycle numbers are counted from the cycle in which start is pulsed.
module tb_melody_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cnum   = 0;
   logic [23:0] rom [4];
   logic [15:0] pat;

   always #5 clk = ~clk;

   melody_sequencer_if #(.DIV_W(16), .DUR_W(8), .ADDR_W(2)) bus ();

   melody_sequencer #(
      .DIV_W(16), .DUR_W(8), .ADDR_W(2), .TICK_DIV(4), .GAP_TICKS(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   function automatic logic [23:0] ent(input int d, input int u);
      return {16'(d), 8'(u)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_to(input int k);
      while (cnum < k) begin
         @(posedge clk);
         #1;
         cnum++;
      end
   endtask

   task automatic begin_play();
      cnum = 0;
      bus.start = 1'b1;
      run_to(1);
      bus.start = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
`ifdef MELODY_LOOP_EN
      bus.loop  = 1'b0;
`endif
      for (int i = 0; i < 4; i++) rom[i] = ent(16'hFFFF, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_addr", 32'(bus.rom_addr), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_note", 32'(bus.note_active), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_sq",   32'(bus.square_wave_final), 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // basic tone div=2 dur=2 then end marker
      rom[0] = ent(2, 2);
      rom[1] = ent(16'hFFFF, 0);
      begin_play();
      chk("t1_busy_c1", 32'(bus.busy), 1);
      run_to(3);
      chk("t1_note_c3", 32'(bus.note_active), 1);
      pat = 16'b0000_0110_0110_0000;   // bit k = square wave in cycle k
      for (int k = 3; k <= 14; k++) begin
         run_to(k);
         chk($sformatf("t1_sq_c%0d", k), 32'(bus.square_wave_final), 32'(pat[k]));
      end
      run_to(11);
      chk("t1_note_gap", 32'(bus.note_active), 0);
      run_to(15);
      chk("t1_addr_c15", 32'(bus.rom_addr), 1);
      run_to(16);
      chk("t1_done_c16", 32'(bus.done), 0);
      run_to(17);
      chk("t1_done_c17", 32'(bus.done), 1);
      chk("t1_busy_c17", 32'(bus.busy), 1);
      run_to(18);
      chk("t1_done_c18", 32'(bus.done), 0);
      chk("t1_busy_c18", 32'(bus.busy), 0);
      chk("t1_addr_c18", 32'(bus.rom_addr), 0);

      // rest then a div=3 tone, stopped mid-note, then replay
      rom[0] = ent(0, 3);
      rom[1] = ent(3, 3);
      rom[2] = ent(16'hFFFF, 0);
      run_to(20);
      begin_play();
      for (int k = 3; k <= 18; k++) begin
         run_to(k);
         chk($sformatf("t2_rest_sq_c%0d", k), 32'(bus.square_wave_final), 0);
         chk($sformatf("t2_rest_na_c%0d", k), 32'(bus.note_active), 0);
      end
      run_to(19);
      chk("t2_addr_c19", 32'(bus.rom_addr), 1);
      run_to(21);
      chk("t2_note_c21", 32'(bus.note_active), 1);
      chk("t2_sq_c21", 32'(bus.square_wave_final), 0);
      run_to(23);
      chk("t2_sq_c23", 32'(bus.square_wave_final), 0);
      run_to(24);
      chk("t2_sq_c24", 32'(bus.square_wave_final), 1);
      run_to(25);
      chk("t2_sq_c25", 32'(bus.square_wave_final), 1);
      bus.stop = 1'b1;
      run_to(26);
      bus.stop = 1'b0;
      chk("t2_stop_busy", 32'(bus.busy), 0);
      chk("t2_stop_sq",   32'(bus.square_wave_final), 0);
      chk("t2_stop_note", 32'(bus.note_active), 0);
      chk("t2_stop_done", 32'(bus.done), 0);
      chk("t2_stop_addr", 32'(bus.rom_addr), 0);
      run_to(27);
      chk("t2_stop_done_c27", 32'(bus.done), 0);
      chk("t2_stop_busy_c27", 32'(bus.busy), 0);
      run_to(28);
      begin_play();
      chk("t2_replay_busy", 32'(bus.busy), 1);
      chk("t2_replay_addr", 32'(bus.rom_addr), 0);
      run_to(3);
      chk("t2_replay_rest", 32'(bus.note_active), 0);
      chk("t2_replay_busy3", 32'(bus.busy), 1);
      // stop and start together: stop wins
      bus.stop  = 1'b1;
      bus.start = 1'b1;
      run_to(4);
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      chk("t2_stopstart_busy", 32'(bus.busy), 0);
      run_to(6);

      // dur=0 entry is skipped, div=1 toggles every cycle
      rom[0] = ent(5, 0);
      rom[1] = ent(1, 1);
      rom[2] = ent(16'hFFFF, 0);
      begin_play();
      run_to(2);
      chk("t3_sq_c2", 32'(bus.square_wave_final), 0);
      chk("t3_na_c2", 32'(bus.note_active), 0);
      run_to(3);
      chk("t3_addr_c3", 32'(bus.rom_addr), 1);
      chk("t3_sq_c3", 32'(bus.square_wave_final), 0);
      run_to(4);
      chk("t3_sq_c4", 32'(bus.square_wave_final), 0);
      run_to(5);
      chk("t3_na_c5", 32'(bus.note_active), 1);
      pat = 16'b0000_0001_0100_0000;
      for (int k = 5; k <= 9; k++) begin
         run_to(k);
         chk($sformatf("t3_sq_c%0d", k), 32'(bus.square_wave_final), 32'(pat[k]));
      end
      run_to(14);
      chk("t3_done_c14", 32'(bus.done), 0);
      run_to(15);
      chk("t3_done_c15", 32'(bus.done), 1);
      run_to(16);
      chk("t3_busy_c16", 32'(bus.busy), 0);
      run_to(18);

      // four tones, no end marker: address wrap ends the melody
      rom[0] = ent(1, 1);
      rom[1] = ent(2, 1);
      rom[2] = ent(1, 1);
      rom[3] = ent(2, 1);
      begin_play();
      run_to(11);
      chk("t4_addr_c11", 32'(bus.rom_addr), 1);
      run_to(13);
      chk("t4_sq_c13", 32'(bus.square_wave_final), 0);
      run_to(15);
      chk("t4_sq_c15", 32'(bus.square_wave_final), 1);
      run_to(21);
      chk("t4_addr_c21", 32'(bus.rom_addr), 2);
      run_to(31);
      chk("t4_addr_c31", 32'(bus.rom_addr), 3);
      run_to(33);
      chk("t4_na_c33", 32'(bus.note_active), 1);
      run_to(40);
      chk("t4_done_c40", 32'(bus.done), 0);
      run_to(41);
      chk("t4_done_c41", 32'(bus.done), 1);
      chk("t4_addr_c41", 32'(bus.rom_addr), 0);
      run_to(42);
      chk("t4_done_c42", 32'(bus.done), 0);
      chk("t4_busy_c42", 32'(bus.busy), 0);
      run_to(44);

      // asynchronous reset mid-note
      begin_play();
      run_to(4);
      chk("t5_sq_before", 32'(bus.square_wave_final), 1);
      rst_n = 1'b0;
      #1;
      chk("t5_sq_async", 32'(bus.square_wave_final), 0);
      chk("t5_busy_async", 32'(bus.busy), 0);
      #1;
      rst_n = 1'b1;
      run_to(6);
      chk("t5_busy_after", 32'(bus.busy), 0);

`ifdef MELODY_LOOP_EN
      rom[0] = ent(1, 1);
      rom[1] = ent(16'hFFFF, 0);
      bus.loop = 1'b1;
      begin_play();
      run_to(12);
      chk("t6_done_c12", 32'(bus.done), 0);
      run_to(13);
      chk("t6_done_c13", 32'(bus.done), 1);
      chk("t6_busy_c13", 32'(bus.busy), 1);
      chk("t6_addr_c13", 32'(bus.rom_addr), 0);
      run_to(14);
      chk("t6_done_c14", 32'(bus.done), 0);
      run_to(15);
      chk("t6_na_c15", 32'(bus.note_active), 1);
      run_to(25);
      chk("t6_done_c25", 32'(bus.done), 1);
      chk("t6_busy_c25", 32'(bus.busy), 1);
      bus.loop = 1'b0;
      run_to(37);
      chk("t6_done_c37", 32'(bus.done), 1);
      run_to(38);
      chk("t6_busy_c38", 32'(bus.busy), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
